// File: rtl/gl_pkg.sv
// rtl/gl_pkg.sv - shared FSM encoding, divider latency default and fp32 field positions
package gl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } pdiv_state_e;

  localparam int DIV_LATENCY_DEF = 4;

  localparam int FP_EXP_MSB = 30;
  localparam int FP_EXP_LSB = 23;
  localparam int FP_MAN_MSB = 22;
  localparam int FP_MAN_LSB = 0;

  // Sign is deliberately not an argument: +0 and -0 are both a zero divisor.
  function automatic logic fp_is_zero(input logic [FP_EXP_MSB:0] mag);
    return (mag[FP_EXP_MSB:FP_EXP_LSB] == '0) && (mag[FP_MAN_MSB:FP_MAN_LSB] == '0);
  endfunction

endpackage

// File: rtl/gl_pdiv_sched.sv
// rtl/gl_pdiv_sched.sv - issue/collect scheduler for x/w, y/w, z/w on a shared fp divider
// Optional zero-w guard: GL_PDIV_ZERO_GUARD_EN
module gl_pdiv_sched
  import gl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_pdiv_en,
  input  logic [127:0] in_vertex,
  input  logic [95:0]  in_color,
  output logic [31:0]  div_a,
  output logic [31:0]  div_b,
  output logic         div_valid,
  input  logic [31:0]  div_res,
  input  logic         div_res_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_vertex,
  output logic [95:0]  out_color,
  output logic         busy,
  output logic         err_w_zero
);

  localparam logic [3:0] DRAIN_INIT = 4'(DIV_LATENCY);

  pdiv_state_e state_q, state_d;
  logic [1:0]  iss_q, iss_d;
  logic [1:0]  res_q, res_d;
  logic [3:0]  drain_q, drain_d;
  logic [31:0] y_q, y_d;
  logic [31:0] z_q, z_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic        div_valid_q, div_valid_d;
  logic [95:0] out_vertex_q, out_vertex_d;
  logic [95:0] out_color_q, out_color_d;
  logic        err_q, err_d;
  logic        accept;

  // Holding in_ready low while draining keeps results of an aborted vertex
  // from ever landing in ISSUE/WAIT, the only states that capture them.
  assign in_ready   = (state_q == ST_IDLE) && (drain_q == '0);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_OUT);
  assign busy       = (state_q != ST_IDLE);
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_valid  = div_valid_q;
  assign out_vertex = out_vertex_q;
  assign out_color  = out_color_q;
  assign err_w_zero = err_q;

  always_comb begin
    state_d      = state_q;
    iss_d        = iss_q;
    res_d        = res_q;
    drain_d      = drain_q;
    y_d          = y_q;
    z_d          = z_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_valid_d  = 1'b0;
    out_vertex_d = out_vertex_q;
    out_color_d  = out_color_q;
    err_d        = err_q;

    if (drain_q != '0) begin
      drain_d = drain_q - 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_color_d = in_color;
          if (!in_pdiv_en) begin
            out_vertex_d = in_vertex[127:32];
            state_d      = ST_OUT;
          end
`ifdef GL_PDIV_ZERO_GUARD_EN
          else if (fp_is_zero(in_vertex[FP_EXP_MSB:0])) begin
            out_vertex_d = '0;
            err_d        = 1'b1;
            state_d      = ST_OUT;
          end
`endif
          else begin
            y_d         = in_vertex[95:64];
            z_d         = in_vertex[63:32];
            div_a_d     = in_vertex[127:96];
            div_b_d     = in_vertex[31:0];
            div_valid_d = 1'b1;
            iss_d       = 2'd0;
            res_d       = 2'd0;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        case (iss_q)
          2'd0: begin
            div_a_d     = y_q;
            div_valid_d = 1'b1;
            iss_d       = 2'd1;
          end
          2'd1: begin
            div_a_d     = z_q;
            div_valid_d = 1'b1;
            iss_d       = 2'd2;
          end
          default: state_d = ST_WAIT;
        endcase
      end
      ST_WAIT: ;
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Results come back in issue order, so the counter picks the slot.
    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && div_res_valid && res_q != 2'd3) begin
      case (res_q)
        2'd0:    out_vertex_d[95:64] = div_res;
        2'd1:    out_vertex_d[63:32] = div_res;
        default: out_vertex_d[31:0]  = div_res;
      endcase
      res_d = res_q + 2'd1;
      if (res_q == 2'd2) begin
        state_d = ST_OUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      iss_q        <= '0;
      res_q        <= '0;
      drain_q      <= DRAIN_INIT;
      y_q          <= '0;
      z_q          <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_valid_q  <= 1'b0;
      out_vertex_q <= '0;
      out_color_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      iss_q        <= iss_d;
      res_q        <= res_d;
      drain_q      <= drain_d;
      y_q          <= y_d;
      z_q          <= z_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_valid_q  <= div_valid_d;
      out_vertex_q <= out_vertex_d;
      out_color_q  <= out_color_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_gl_pdiv_sched.sv
// tb/tb_gl_pdiv_sched.sv - scoreboard bench for gl_pdiv_sched with a behavioural divider
module tb_gl_pdiv_sched;

  localparam int L = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_pdiv_en;
  logic [127:0] in_vertex;
  logic [95:0]  in_color;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic         div_valid;
  logic [31:0]  div_res;
  logic         div_res_valid;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_vertex;
  logic [95:0]  out_color;
  logic         busy;
  logic         err_w_zero;
  logic         stray;

  gl_pdiv_sched #(.DIV_LATENCY(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pdiv_en    (in_pdiv_en),
    .in_vertex     (in_vertex),
    .in_color      (in_color),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_valid     (div_valid),
    .div_res       (div_res),
    .div_res_valid (div_res_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_vertex    (out_vertex),
    .out_color     (out_color),
    .busy          (busy),
    .err_w_zero    (err_w_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_iss  = 0;
  int n_res  = 0;
  logic seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0)          d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF)    d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                           d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0)    return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF)  return {d[63], 8'hFF, d[51:29]};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Behavioural divider: result appears L cycles after the issue cycle.
  logic [L-1:0] pv = '0;
  logic [31:0]  pd [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], div_valid};
    pd[0] <= r2sp(sp2r(div_a) / sp2r(div_b));
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign div_res_valid = pv[L-1] | stray;
  assign div_res       = stray ? 32'hDEADBEEF : pd[L-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_res_valid) n_res = n_res + 1;
  end

  typedef struct {
    logic [95:0] vtx;
    logic [95:0] col;
    int          lat;
    int          xcyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t e_m;

  always @(negedge clk) begin
    if (div_valid) n_iss++;
    if (reset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 128'(1), 128'(0));
      end else begin
        if (!seen) begin
          check("latency", 128'(cyc - sb_q[0].xcyc), 128'(sb_q[0].lat));
          seen = 1'b1;
        end
        if (out_ready) begin
          e_m = sb_q.pop_front();
          check("out_vertex", 128'(out_vertex), 128'(e_m.vtx));
          check("out_color", 128'(out_color), 128'(e_m.col));
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [127:0] v, input logic [95:0] c, input logic en,
                      input logic [95:0] exp_v, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 128'(in_ready), 128'(1));
    in_vertex  = v;
    in_color   = c;
    in_pdiv_en = en;
    in_valid   = 1'b1;
    sb_q.push_back('{exp_v, c, lat, cyc});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 128'(sb_q.size()), 128'(0));
  endtask

  // Caller is positioned at a negedge.
  task automatic do_reset();
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_div_valid", 128'(div_valid), 128'(0));
    check("rst_err", 128'(err_w_zero), 128'(0));
    check("rst_out_vertex", 128'(out_vertex), 128'(0));
    check("rst_out_color", 128'(out_color), 128'(0));
    check("rst_div_a", 128'(div_a), 128'(0));
    check("rst_div_b", 128'(div_b), 128'(0));
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_drain_cycles", 128'(n), 128'(L));
  endtask

  localparam logic [127:0] V_A = {32'h40800000, 32'h41000000, 32'h3F800000, 32'h40000000};
  localparam logic [95:0]  Q_A = {32'h40000000, 32'h40800000, 32'h3F000000};
  localparam logic [127:0] V_B = {32'h40C00000, 32'hC0400000, 32'h3FC00000, 32'h3F000000};
  localparam logic [95:0]  Q_B = {32'h41400000, 32'hC0C00000, 32'h40400000};
  localparam logic [127:0] V_C = {32'h3F800000, 32'h40400000, 32'hC1000000, 32'hC0800000};
  localparam logic [95:0]  Q_C = {32'hBE800000, 32'hBF400000, 32'h40000000};
  localparam logic [127:0] V_Z = {32'h40800000, 32'h41000000, 32'h3F800000, 32'h00000000};
  localparam logic [95:0]  C1  = 96'h001122334455667788_99AABB;
  localparam logic [95:0]  C2  = 96'hCAFEF00D_12345678_0BADBEEF;
  localparam logic [95:0]  C3  = 96'h0F0F0F0F_F0F0F0F0_A5A5A5A5;

  int iss0;
  int res0;
  int nw;

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_pdiv_en = 1'b0;
    in_vertex  = '0;
    in_color   = '0;
    out_ready  = 1'b1;
    stray      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    // stray result pulse while idle
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("stray_idle_busy", 128'(busy), 128'(0));
    check("stray_idle_out_valid", 128'(out_valid), 128'(0));
    check("stray_idle_in_ready", 128'(in_ready), 128'(1));

    // divide
    iss0 = n_iss;
    send(V_A, C1, 1'b1, Q_A, L + 4);
    wait_done();
    check("div_a_issues", 128'(n_iss - iss0), 128'(3));

    // bypass
    iss0 = n_iss;
    send(V_A, C2, 1'b0, V_A[127:32], 1);
    wait_done();
    check("bypass_issues", 128'(n_iss - iss0), 128'(0));

    iss0 = n_iss;
    send(V_B, C2, 1'b1, Q_B, L + 4);
    send(V_C, C3, 1'b1, Q_C, L + 4);
    wait_done();
    check("div_bc_issues", 128'(n_iss - iss0), 128'(6));

    // backpressure in OUT, with a stray fourth pulse mixed in
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(V_B, C1, 1'b1, Q_B, L + 4);
    nw = 0;
    @(negedge clk);
    while (!out_valid && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    check("bp_reached_out", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      stray = (i == 2);
      check("bp_vertex", 128'(out_vertex), 128'(Q_B));
      check("bp_color", 128'(out_color), 128'(C1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_valid", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    stray = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 128'(in_ready), 128'(1));
    check("bp_out_valid_after", 128'(out_valid), 128'(0));
    check("bp_sb_empty", 128'(sb_q.size()), 128'(0));

    // reset in WAIT after the first result has been stored
    res0 = n_res;
    send(V_C, C2, 1'b1, Q_C, L + 4);
    nw = 0;
    while (n_res == res0 && nw < 40) begin
      @(negedge clk);
      nw++;
    end
    check("mid_wait_busy", 128'(busy), 128'(1));
    do_reset();
    repeat (4) @(negedge clk);
    check("late_res_busy", 128'(busy), 128'(0));
    check("late_res_out_valid", 128'(out_valid), 128'(0));
    send(V_A, C3, 1'b1, Q_A, L + 4);
    wait_done();

    // zero w
    iss0 = n_iss;
`ifdef GL_PDIV_ZERO_GUARD_EN
    send(V_Z, C3, 1'b1, 96'h0, 1);
    wait_done();
    check("zero_w_issues", 128'(n_iss - iss0), 128'(0));
    check("zero_w_err", 128'(err_w_zero), 128'(1));
    send(V_B, C1, 1'b1, Q_B, L + 4);
    wait_done();
    check("zero_w_err_sticky", 128'(err_w_zero), 128'(1));
`else
    send(V_Z, C3, 1'b1, {3{32'h7F800000}}, L + 4);
    wait_done();
    check("zero_w_issues", 128'(n_iss - iss0), 128'(3));
    check("zero_w_err", 128'(err_w_zero), 128'(0));
    send(V_B, C1, 1'b1, Q_B, L + 4);
    wait_done();
    check("zero_w_err_later", 128'(err_w_zero), 128'(0));
`endif
    @(negedge clk);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
